mips_muldiv_unit: RTL and testbench

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

---
 rtl/mips_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: one result bit per enabled cycle,
// shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                bzero_q, bzero_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2*WIDTH:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q;
  logic                done_q, done_d;

  logic                start_signed;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH:0]      div_rem;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_p(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign start_signed = ~op[0];
  assign mag_a        = magnitude(op_a, start_signed);
  assign mag_b        = magnitude(op_b, start_signed);

  // acc layout: multiply = {partial product, remaining multiplier bits};
  // divide = {1'b0, remainder, dividend bits still to shift in / quotient bits}
  assign mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          qneg_d   = start_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          rneg_d   = start_signed & op_a[WIDTH-1];
          bzero_d  = (op_b == '0);
          a_d      = mag_a;
          b_d      = mag_b;
          acc_d    = {{(WIDTH+1){1'b0}}, (op[1] ? mag_a : mag_b)};
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      CALC: begin
        acc_d = is_div_q ? {1'b0, div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge}
                         : {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Divide-by-zero: remainder already equals the dividend; quotient forced to all ones
          lo_d = bzero_q ? '1 : neg_w(acc_q[WIDTH-1:0], qneg_q);
          hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], rneg_q);
        end else begin
          {hi_d, lo_d} = neg_p(acc_q[2*WIDTH-1:0], qneg_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else if (clock_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    done_q <= ~reset & clock_enable & done_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (clock_enable) begin
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32): expected {hi,lo} queued at start,
// popped and compared when done pulses.
module tb_mips_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, clock_enable, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] op_a, op_b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    model = '0;
    case (o)
      2'b00: model = sa * sb;
      2'b01: model = ua * ub;
      2'b10: begin
        if (b == 32'h0) model = {a, 32'hFFFFFFFF};
        else begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'h0) model = {a, 32'hFFFFFFFF};
        else begin q = ua / ub; r = ua % ub; model = {r[31:0], q[31:0]}; end
      end
    endcase
  endfunction

  // Called 1ns after an edge with the DUT idle; returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    op = o; op_a = a; op_b = b; start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(output int lat, output bit seen);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF0000;
    clock_enable = 1'b0; op = 2'b00; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    clock_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_priority: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    logic [1:0]  ops[5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [31:0] as[5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h7FFFFFFF};
    logic [31:0] bs[5]  = '{32'h00000005, 32'hFFFFFFFF, 32'h80000000, 32'h9ABCDEF0, 32'hFFFFFFFF};
    logic [63:0] exps[5] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001, 64'h40000000_00000000,
                             64'h0B00EA4E_242D2080, 64'hFFFFFFFF_80000001};
    logic [63:0] exp;
    int lat; bit seen;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], exps[i]);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d]: busy=%b want 1", i, busy); end
      wait_done(lat, seen);
      checks++;
      if (!seen || lat != 33) begin
        errors++; $display("FAIL mult_latency[%0d]: got %0d cycles seen=%0b, want 33", i, lat, seen);
      end
      exp = sb_q.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin
        errors++; $display("FAIL mult_result[%0d]: got hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, exp[63:32], exp[31:0]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mult_done_pulse[%0d]: done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops[6] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [31:0] as[6]  = '{32'hFFFFFFF9, 32'd7, 32'h00001234, 32'h80000000, 32'hFFFFFFF9, 32'd100};
    logic [31:0] bs[6]  = '{32'h00000002, 32'd2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFF9};
    logic [63:0] exps[6] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003, 64'h00001234_FFFFFFFF,
                             64'h00000000_80000000, 64'hFFFFFFF9_FFFFFFFF, 64'h00000002_FFFFFFF2};
    logic [63:0] exp;
    int lat; bit seen;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], exps[i]);
      wait_done(lat, seen);
      checks++;
      if (!seen || lat != 33) begin
        errors++; $display("FAIL div_latency[%0d]: got %0d cycles seen=%0b, want 33", i, lat, seen);
      end
      exp = sb_q.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin
        errors++; $display("FAIL div_result[%0d]: got hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_stall;
    logic [63:0] exp;
    int lat = 0; bit seen = 1'b0; int dones = 0;
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, model(2'b00, 32'h12345678, 32'h9ABCDEF0));
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      start = (cyc == 3);
      if (cyc == 3) begin op = 2'b11; op_a = 32'd100; op_b = 32'd7; end
      clock_enable = !(cyc >= 10 && cyc < 15);
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; lat = cyc; end
    end
    start = 1'b0; clock_enable = 1'b1;
    checks++;
    if (!seen || lat != 38) begin
      errors++; $display("FAIL stall_latency: got %0d cycles seen=%0b, want 38", lat, seen);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++; $display("FAIL stall_result: got hi=%h lo=%h, want hi=%h lo=%h", hi, lo, exp[63:32], exp[31:0]);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL stall_ignored_start: saw %0d busy/done cycles, want 0", dones);
    end
  endtask

  task automatic test_reset_midop;
    int dones = 0;
    issue(2'b00, 32'd7, 32'd9, model(2'b00, 32'd7, 32'd9));
    for (int cyc = 1; cyc <= 9; cyc++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL midop_reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || hi !== 32'h0 || lo !== 32'h0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL midop_no_done: saw %0d done/write cycles, want 0", dones);
    end
    mthi = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'h0) begin
      errors++; $display("FAIL midop_mthi: hi=%h lo=%h, want A5A5A5A5 00000000", hi, lo);
    end
  endtask

  task automatic test_moves;
    logic [63:0] exp;
    int lat; bit seen;
    mtlo = 1'b1; wdata = 32'h22222222;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'h22222222) begin
      errors++; $display("FAIL move_mtlo: hi=%h lo=%h, want A5A5A5A5 22222222", hi, lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h33333333;
    @(posedge clk); #1;
    checks++;
    if (hi !== 32'h33333333 || lo !== 32'h33333333) begin
      errors++; $display("FAIL move_both: hi=%h lo=%h, want 33333333 33333333", hi, lo);
    end
    mtlo = 1'b0; wdata = 32'h44444444; clock_enable = 1'b0;
    @(posedge clk); #1;
    clock_enable = 1'b1; mthi = 1'b0;
    checks++;
    if (hi !== 32'h33333333) begin
      errors++; $display("FAIL move_stalled: hi=%h, want 33333333", hi);
    end
    mthi = 1'b1; wdata = 32'h55555555;
    issue(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E);
    mthi = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== 32'h33333333) begin
      errors++; $display("FAIL move_with_start: busy=%b hi=%h, want 1 33333333", busy, hi);
    end
    wait_done(lat, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || {hi, lo} !== exp) begin
      errors++; $display("FAIL move_start_result: seen=%0b hi=%h lo=%h, want hi=%h lo=%h", seen, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_move_busy;
    logic [63:0] exp;
    int lat = 0; bit seen = 1'b0; int bad = 0;
    mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mtlo = 1'b0;
    issue(2'b01, 32'd3, 32'd5, 64'h00000000_0000000F);
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      mtlo = (cyc == 5); mthi = (cyc == 5); wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; lat = cyc; end
      else if (lo !== 32'hCAFEF00D) bad++;
    end
    mtlo = 1'b0; mthi = 1'b0;
    checks++;
    if (bad != 0 || !seen || lat != 33) begin
      errors++; $display("FAIL busy_move: %0d cycles with lo changed, latency %0d seen=%0b, want 0 33 1", bad, lat, seen);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++; $display("FAIL busy_move_result: hi=%h lo=%h, want hi=%h lo=%h", hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    logic [1:0] o; logic [31:0] a, b;
    int lat; bit seen;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? 32'h0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
      issue(o, a, b, model(o, a, b));
      wait_done(lat, seen);
      exp = sb_q.pop_front();
      checks++;
      if (!seen || lat != 33 || {hi, lo} !== exp) begin
        errors++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h: lat=%0d seen=%0b hi=%h lo=%h, want lat 33 hi=%h lo=%h", i, o, a, b, lat, seen, hi, lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clock_enable = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; op_a = '0; op_b = '0; wdata = '0;
    #1;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_reset_midop();
    test_moves();
    test_move_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
